// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the fetch-address generator.
// Holds stall, branch, chip-enable and reset levels plus the FSM encoding.
package pc_gen_pkg;

   typedef enum logic {
      StBoot = 1'b0,
      StRun  = 1'b1
   } pc_state_e;

   localparam int unsigned StallFetchBit = 0;
   localparam logic        StallActive   = 1'b1;
   localparam logic        BranchTaken   = 1'b1;
   localparam logic        FlushActive   = 1'b1;
   localparam logic        ChipEnable    = 1'b1;
   localparam logic        ChipDisable   = 1'b0;
   localparam logic        RstActive     = 1'b0;

endpackage

// File: rtl/pc_gen.sv
// Fetch program-counter generator: boot/run FSM, flush and branch redirects,
// a single pending-branch slot for branches that arrive during a fetch stall.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
   parameter int unsigned       INST_BYTES = 4,
   parameter int unsigned       STALL_W    = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               branch_flag_i,
   input  logic [ADDR_W-1:0]  branch_target_address_i,
   input  logic               flush_i,
   input  logic [ADDR_W-1:0]  new_pc_i,
   output logic [ADDR_W-1:0]  pc,
   output logic               ce,
   output logic               redirect_o,
   output logic               misalign_o
);

   // Low address bits that must be zero in an aligned fetch address.
   localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(INST_BYTES - 1);
   localparam logic [ADDR_W-1:0] PcStep    = ADDR_W'(INST_BYTES);

   pc_state_e         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              pend_vld_q, pend_vld_d;
   logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
   logic              redirect_q, redirect_d;
   logic              misalign_q, misalign_d;

   logic              load_en;
   logic [ADDR_W-1:0] load_raw;
   logic              fetch_stall;

   assign fetch_stall = (stall[StallFetchBit] == StallActive);

   if (STALL_W > 1) begin : g_unused_stall
      logic unused_stall_hi;
      assign unused_stall_hi = ^stall[STALL_W-1:1];
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_vld_d = pend_vld_q;
      pend_tgt_d = pend_tgt_q;
      redirect_d = 1'b0;
      misalign_d = 1'b0;
      load_en    = 1'b0;
      load_raw   = '0;

      unique case (state_q)
         StBoot: begin
            state_d = StRun;
         end
         StRun: begin
            if (flush_i == FlushActive) begin
               load_en    = 1'b1;
               load_raw   = new_pc_i;
               pend_vld_d = 1'b0;
               pend_tgt_d = '0;
            end else if (fetch_stall) begin
               // Latest branch seen during the stall wins.
               if (branch_flag_i == BranchTaken) begin
                  pend_vld_d = 1'b1;
                  pend_tgt_d = branch_target_address_i;
               end
            end else if (branch_flag_i == BranchTaken) begin
               load_en    = 1'b1;
               load_raw   = branch_target_address_i;
               pend_vld_d = 1'b0;
               pend_tgt_d = '0;
            end else if (pend_vld_q) begin
               load_en    = 1'b1;
               load_raw   = pend_tgt_q;
               pend_vld_d = 1'b0;
               pend_tgt_d = '0;
            end else begin
               pc_d = pc_q + PcStep;
            end
         end
      endcase

      if (load_en) begin
         pc_d       = load_raw & ~AlignMask;
         redirect_d = 1'b1;
         misalign_d = |(load_raw & AlignMask);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstActive) begin
         state_q    <= StBoot;
         pc_q       <= RESET_VEC;
         pend_vld_q <= 1'b0;
         pend_tgt_q <= '0;
         redirect_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_vld_q <= pend_vld_d;
         pend_tgt_q <= pend_tgt_d;
         redirect_q <= redirect_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc         = pc_q;
   assign ce         = (state_q == StRun) ? ChipEnable : ChipDisable;
   assign redirect_o = redirect_q;
   assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: a 32-bit and an 8-bit instance share stimulus and are
// compared every cycle against a behavioural fetch-address model.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  stall = '0;
   logic        br = 1'b0;
   logic [31:0] tgt = '0;
   logic        flush = 1'b0;
   logic [31:0] npc = '0;

   logic [31:0] pc32;
   logic        ce32, redir32, mis32;
   logic [7:0]  pc8;
   logic        ce8, redir8, mis8;

   int errors = 0;
   int checks = 0;

   // Model state, index 0 = 32-bit instance, 1 = 8-bit instance.
   longint m_pc[2];
   bit     m_run[2];
   bit     m_redir[2];
   bit     m_mis[2];
   bit     m_pv[2];
   longint m_pt[2];

   always #5 clk = ~clk;

   pc_gen u_dut32 (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .branch_flag_i           (br),
      .branch_target_address_i (tgt),
      .flush_i                 (flush),
      .new_pc_i                (npc),
      .pc                      (pc32),
      .ce                      (ce32),
      .redirect_o              (redir32),
      .misalign_o              (mis32)
   );

   pc_gen #(
      .ADDR_W    (8),
      .RESET_VEC (8'h00)
   ) u_dut8 (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .branch_flag_i           (br),
      .branch_target_address_i (tgt[7:0]),
      .flush_i                 (flush),
      .new_pc_i                (npc[7:0]),
      .pc                      (pc8),
      .ce                      (ce8),
      .redirect_o              (redir8),
      .misalign_o              (mis8)
   );

   function automatic longint addr_mod(int k);
      return (k == 0) ? 64'h1_0000_0000 : 64'h100;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = 0; m_run[k] = 0; m_redir[k] = 0; m_mis[k] = 0;
         m_pv[k] = 0; m_pt[k] = 0;
      end
   endtask

   task automatic model_load(int k, longint raw);
      longint t;
      t          = raw % addr_mod(k);
      m_mis[k]   = (t % 4) != 0;
      m_pc[k]    = t - (t % 4);
      m_redir[k] = 1;
   endtask

   // One rising edge of the specified behaviour, sampled on the current inputs.
   task automatic model_edge(int k);
      m_redir[k] = 0;
      m_mis[k]   = 0;
      if (!m_run[k]) begin
         m_run[k] = 1;
      end else if (flush) begin
         model_load(k, longint'(npc));
         m_pv[k] = 0;
      end else if (stall[0]) begin
         if (br) begin
            m_pv[k] = 1;
            m_pt[k] = longint'(tgt);
         end
      end else if (br) begin
         model_load(k, longint'(tgt));
         m_pv[k] = 0;
      end else if (m_pv[k]) begin
         model_load(k, m_pt[k]);
         m_pv[k] = 0;
      end else begin
         m_pc[k] = (m_pc[k] + 4) % addr_mod(k);
      end
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("pc32", pc32, 32'(m_pc[0]));
      check("ce32", {31'b0, ce32}, {31'b0, m_run[0]});
      check("redirect32", {31'b0, redir32}, {31'b0, m_redir[0]});
      check("misalign32", {31'b0, mis32}, {31'b0, m_mis[0]});
      check("pc8", {24'b0, pc8}, 32'(m_pc[1]));
      check("ce8", {31'b0, ce8}, {31'b0, m_run[1]});
      check("redirect8", {31'b0, redir8}, {31'b0, m_redir[1]});
      check("misalign8", {31'b0, mis8}, {31'b0, m_mis[1]});
   endtask

   task automatic drive(logic s, logic b, logic [31:0] bt, logic f, logic [31:0] np);
      stall = {stall[5:1], s};
      br    = b;
      tgt   = bt;
      flush = f;
      npc   = np;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      check("reset_pc", pc32, 32'h0);
      check("reset_ce", {31'b0, ce32}, 32'h0);

      // Boot then sequential fetch.
      rst = 1'b1;
      #1;
      check("boot_ce", {31'b0, ce32}, 32'h0);
      step();
      check("run_first_pc", pc32, 32'h0);
      check("run_first_ce", {31'b0, ce32}, 32'h1);
      step(); step(); step();
      check("seq_pc12", pc32, 32'h0C);

      // Unstalled branch.
      drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
      step();
      check("br_pc", pc32, 32'h100);
      check("br_redirect", {31'b0, redir32}, 32'h1);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      check("br_next", pc32, 32'h104);
      check("br_redirect_off", {31'b0, redir32}, 32'h0);

      // Two branches during a three-cycle stall: the later one wins.
      drive(1'b1, 1'b1, 32'h200, 1'b0, 32'h0); step();
      drive(1'b1, 1'b1, 32'h300, 1'b0, 32'h0); step();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);   step();
      check("stall_hold", pc32, 32'h104);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);   step();
      check("pend_apply", pc32, 32'h300);
      step();
      check("pend_next", pc32, 32'h304);

      // Flush during a stall discards the pending branch.
      drive(1'b1, 1'b1, 32'h500, 1'b0, 32'h0); step();
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h20);  step();
      check("flush_pc", pc32, 32'h20);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);   step();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);   step();
      check("flush_discard", pc32, 32'h24);

      // 8-bit wrap and misaligned target.
      drive(1'b0, 1'b1, 32'hFC, 1'b0, 32'h0);  step();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);   step();
      check("wrap8", {24'b0, pc8}, 32'h00);
      drive(1'b0, 1'b1, 32'h13, 1'b0, 32'h0);  step();
      check("misalign_pc8", {24'b0, pc8}, 32'h10);
      check("misalign_pulse", {31'b0, mis8}, 32'h1);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);   step();
      check("misalign_off", {31'b0, mis8}, 32'h0);

      // Reset mid-stall with a branch pending.
      drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);  step();
      do_reset();
      step();
      check("rst_restart", pc32, 32'h0);
      step();
      check("rst_no_pend", pc32, 32'h4);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] rt, rn;
         rt = $urandom();
         rn = $urandom();
         stall = 6'($urandom());
         drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 25, rt,
               $urandom_range(0, 99) < 8, rn);
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
